// File: rtl/muldiv_unit.sv
// RV64M execute-stage controller: conditions operands for an external two-cycle
// multiplier and runs an internal restoring divider with RISC-V sign/W fix-ups.
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] c,
  output logic            mul_valid,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  input  logic            mul_done,
  input  logic [XLEN-1:0] mul_c
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL_WAIT = 3'd1,
    ST_DIV_RUN  = 3'd2,
    ST_DIV_FIX  = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [3:0] OP_MUL  = 4'd0;
  localparam logic [3:0] OP_MULW = 4'd1;
  localparam logic [3:0] OP_LAST = 4'd9;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic is_signed_div(input logic [3:0] o);
    return (o == 4'd2) || (o == 4'd4) || (o == 4'd6) || (o == 4'd8);
  endfunction

  function automatic logic is_word_div(input logic [3:0] o);
    return (o >= 4'd6) && (o <= 4'd9);
  endfunction

  function automatic logic is_rem_op(input logic [3:0] o);
    return (o == 4'd4) || (o == 4'd5) || (o == 4'd8) || (o == 4'd9);
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [63:0] c_q, c_d;
  logic        done_q, done_d;
  logic        mul_valid_q, mul_valid_d;
  logic [63:0] mul_a_q, mul_a_d;
  logic [63:0] mul_b_q, mul_b_d;
  logic [64:0] rem_q, rem_d;
  logic [63:0] quo_q, quo_d;
  logic [63:0] dvs_q, dvs_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        special_q, special_d;

  logic        prep_word_s, prep_signed_s, div_zero_s, ovf_s;
  logic [63:0] dvd_s, dvs_s, mag_a_s, mag_b_s;
  logic [65:0] shifted_s, diff_s;
  logic [63:0] fix_q_s, fix_r_s, fix_sel_s, fix_res_s;

  // Operand conditioning of the raw request for a divide.
  always_comb begin
    prep_word_s   = is_word_div(op);
    prep_signed_s = is_signed_div(op);
    if (prep_word_s) begin
      dvd_s = prep_signed_s ? sext32(a[31:0]) : {32'd0, a[31:0]};
      dvs_s = prep_signed_s ? sext32(b[31:0]) : {32'd0, b[31:0]};
    end else begin
      dvd_s = a;
      dvs_s = b;
    end
    mag_a_s    = (prep_signed_s && dvd_s[63]) ? (64'd0 - dvd_s) : dvd_s;
    mag_b_s    = (prep_signed_s && dvs_s[63]) ? (64'd0 - dvs_s) : dvs_s;
    div_zero_s = (dvs_s == 64'd0);
    ovf_s      = prep_signed_s && (dvs_s == 64'hFFFF_FFFF_FFFF_FFFF) &&
                 (dvd_s == (prep_word_s ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  end

  // One restoring-division step and the final sign/width fix-up.
  always_comb begin
    shifted_s = {rem_q, quo_q[63]};
    diff_s    = shifted_s - {2'b00, dvs_q};
    fix_q_s   = quo_q;
    fix_r_s   = rem_q[63:0];
    if (!special_q && is_signed_div(op_q)) begin
      if (sign_a_q ^ sign_b_q) begin
        fix_q_s = 64'd0 - quo_q;
      end else begin
        fix_q_s = quo_q;
      end
      if (sign_a_q) begin
        fix_r_s = 64'd0 - rem_q[63:0];
      end else begin
        fix_r_s = rem_q[63:0];
      end
    end else begin
      fix_q_s = quo_q;
      fix_r_s = rem_q[63:0];
    end
    fix_sel_s = is_rem_op(op_q) ? fix_r_s : fix_q_s;
    fix_res_s = is_word_div(op_q) ? sext32(fix_sel_s[31:0]) : fix_sel_s;
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    c_d         = c_q;
    done_d      = 1'b0;
    mul_valid_d = mul_valid_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    special_d   = special_q;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          op_d      = op;
          mul_a_d   = a;
          mul_b_d   = b;
          sign_a_d  = prep_signed_s & dvd_s[63];
          sign_b_d  = prep_signed_s & dvs_s[63];
          special_d = 1'b0;
          if ((op == OP_MUL) || (op == OP_MULW)) begin
            mul_valid_d = 1'b1;
            state_d     = ST_MUL_WAIT;
          end else if (op <= OP_LAST) begin
            // Special cases preload the final quotient/remainder and skip iteration.
            if (div_zero_s) begin
              quo_d     = 64'hFFFF_FFFF_FFFF_FFFF;
              rem_d     = {1'b0, dvd_s};
              special_d = 1'b1;
              state_d   = ST_DIV_FIX;
            end else if (ovf_s) begin
              quo_d     = dvd_s;
              rem_d     = 65'd0;
              special_d = 1'b1;
              state_d   = ST_DIV_FIX;
            end else begin
              quo_d   = prep_word_s ? {mag_a_s[31:0], 32'd0} : mag_a_s;
              rem_d   = 65'd0;
              dvs_d   = mag_b_s;
              cnt_d   = prep_word_s ? 7'd32 : 7'd64;
              state_d = ST_DIV_RUN;
            end
          end else begin
            c_d     = 64'd0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL_WAIT: begin
        if (mul_done) begin
          c_d         = (op_q == OP_MULW) ? sext32(mul_c[31:0]) : mul_c;
          mul_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_MUL_WAIT;
        end
      end
      ST_DIV_RUN: begin
        if (!diff_s[65]) begin
          rem_d = diff_s[64:0];
          quo_d = {quo_q[62:0], 1'b1};
        end else begin
          rem_d = shifted_s[64:0];
          quo_d = {quo_q[62:0], 1'b0};
        end
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          state_d = ST_DIV_FIX;
        end else begin
          state_d = ST_DIV_RUN;
        end
      end
      ST_DIV_FIX: begin
        c_d     = fix_res_s;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= 4'd0;
      c_q         <= 64'd0;
      done_q      <= 1'b0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= 64'd0;
      mul_b_q     <= 64'd0;
      rem_q       <= 65'd0;
      quo_q       <= 64'd0;
      dvs_q       <= 64'd0;
      cnt_q       <= 7'd0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      special_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      c_q         <= c_d;
      done_q      <= done_d;
      mul_valid_q <= mul_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      special_q   <= special_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign c         = c_q;
  assign mul_valid = mul_valid_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against a plain-arithmetic RV64M
// model, with a behavioural two-cycle multiplier attached.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [3:0]  op;
  logic [63:0] a, b;
  logic        busy, done, mul_valid, mul_done;
  logic [63:0] c, mul_a, mul_b, mul_c;
  logic [1:0]  mul_cnt;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .c(c), .mul_valid(mul_valid),
    .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_c(mul_c)
  );

  // Two-cycle multiplier: completes in the second consecutive cycle of mul_valid.
  always @(posedge clk) begin
    if (!reset || !mul_valid) mul_cnt <= 2'd0;
    else                      mul_cnt <= mul_cnt + 2'd1;
  end
  assign mul_done = mul_valid && (mul_cnt == 2'd1);
  assign mul_c    = mul_a * mul_b;

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
    longint          sxx, syy;
    int              wx, wy;
    int unsigned     ux, uy;
    logic [63:0]     p;
    logic            ovf64, ovf32;
    sxx = x; syy = y; wx = x[31:0]; wy = y[31:0]; ux = x[31:0]; uy = y[31:0];
    p = x * y;
    ovf64 = (x == 64'h8000_0000_0000_0000) && (y == 64'hFFFF_FFFF_FFFF_FFFF);
    ovf32 = (x[31:0] == 32'h8000_0000) && (y[31:0] == 32'hFFFF_FFFF);
    case (o)
      4'd0: return p;
      4'd1: return sx(p[31:0]);
      4'd2: return (y == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : (ovf64 ? x : 64'(sxx / syy));
      4'd3: return (y == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : x / y;
      4'd4: return (y == 64'd0) ? x : (ovf64 ? 64'd0 : 64'(sxx % syy));
      4'd5: return (y == 64'd0) ? x : x % y;
      4'd6: return (wy == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (ovf32 ? sx(x[31:0]) : sx(32'(wx / wy)));
      4'd7: return (uy == 32'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : sx(ux / uy);
      4'd8: return (wy == 0) ? sx(x[31:0]) : (ovf32 ? 64'd0 : sx(32'(wx % wy)));
      4'd9: return (uy == 32'd0) ? sx(x[31:0]) : sx(ux % uy);
      default: return 64'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
    logic sgn, word, special;
    if (o <= 4'd1) return 3;
    if (o > 4'd9) return 1;
    sgn  = (o == 4'd2) || (o == 4'd4) || (o == 4'd6) || (o == 4'd8);
    word = (o >= 4'd6);
    if (word) special = (y[31:0] == 32'd0) || (sgn && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF);
    else      special = (y == 64'd0) || (sgn && x == 64'h8000_0000_0000_0000 && y == 64'hFFFF_FFFF_FFFF_FFFF);
    if (special) return 2;
    return word ? 34 : 66;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
    int          lat, mv, exp_lat;
    bit          got;
    logic [63:0] exp_c;
    exp_c   = ref_result(o, x, y);
    exp_lat = ref_latency(o, x, y);
    @(negedge clk);
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
    valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 valid = 1'b0; a = 64'd0; b = 64'd0;
    lat = 0; mv = 0; got = 1'b0;
    for (int i = 1; i <= 200 && !got; i++) begin
      @(negedge clk);
      lat = i;
      if (mul_valid) begin
        mv++;
        check({tag, "_mul_a"}, mul_a, x);
        check({tag, "_mul_b"}, mul_b, y);
      end
      if (done) got = 1'b1;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_c"}, c, exp_c);
    if (o <= 4'd1) check({tag, "_mul_valid_cycles"}, 64'(mv), 64'd2);
    @(negedge clk);
    check({tag, "_busy_after"}, {62'd0, busy, done}, 64'd0);
    check({tag, "_c_hold"}, c, exp_c);
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [63:0] r_a, r_b;
    reset = 1'b0; valid = 1'b0; op = 4'd0; a = 64'd0; b = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", {60'd0, busy, done, mul_valid, mul_done}, 64'd0);
    check("reset_c", c, 64'd0);
    check("reset_mul_a", mul_a, 64'd0);
    check("reset_mul_b", mul_b, 64'd0);
    reset = 1'b1;

    do_op("mul",   4'd0, 64'd3, 64'd5);
    do_op("mulw",  4'd1, 64'h7FFF_FFFF, 64'd2);
    do_op("div",   4'd2, -64'sd7, 64'd2);
    do_op("rem",   4'd4, -64'sd7, 64'd2);
    do_op("divu",  4'd3, 64'd100, 64'd7);
    do_op("remu",  4'd5, 64'd100, 64'd7);
    do_op("divu0", 4'd3, 64'h1234, 64'd0);
    do_op("remu0", 4'd5, 64'h1234, 64'd0);
    do_op("divov", 4'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op("remov", 4'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op("divuw", 4'd7, 64'h8000_0000, 64'd1);
    do_op("remw",  4'd8, -64'sd9, 64'd4);
    do_op("divwov", 4'd6, 64'h1234_5678_8000_0000, 64'h0000_0001_FFFF_FFFF);
    do_op("remw0", 4'd8, 64'hAAAA_AAAA_F000_0001, 64'hFFFF_FFFF_0000_0000);
    do_op("illegal", 4'd12, 64'd1, 64'd1);

    for (int n = 0; n < 24; n++) begin
      r_op = 4'($urandom_range(0, 9));
      r_a  = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: r_b = 64'd0;
        1: r_b = 64'hFFFF_FFFF_FFFF_FFFF;
        2: r_b = 64'($urandom_range(1, 1000));
        default: r_b = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 3) == 0) r_a = 64'h8000_0000_0000_0000;
      do_op($sformatf("rand%0d_op%0d", n, r_op), r_op, r_a, r_b);
    end

    // Reset in the middle of a long divide discards it.
    do_op("pre_reset", 4'd3, 64'd1000, 64'd3);
    @(negedge clk);
    valid = 1'b1; op = 4'd2; a = 64'h0123_4567_89AB_CDEF; b = 64'd3;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_div_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_flags", {61'd0, busy, done, mul_valid}, 64'd0);
    check("mid_reset_c", c, 64'd0);
    reset = 1'b1;

    // Held valid: illegal requests complete every other cycle.
    @(negedge clk);
    valid = 1'b1; op = 4'd12; a = 64'd7; b = 64'd9;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("b2b_ill_done%0d", k), {63'd0, done}, {63'd0, (k % 2 == 1)});
      if (k % 2 == 1) check($sformatf("b2b_ill_c%0d", k), c, 64'd0);
    end
    op = 4'd0; a = 64'd3; b = 64'd5;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("b2b_mul_done%0d", k), {63'd0, done}, {63'd0, (k % 4 == 3)});
      if (k % 4 == 3) check($sformatf("b2b_mul_c%0d", k), c, 64'd15);
    end
    valid = 1'b0;
    @(negedge clk);
    check("final_idle", {62'd0, busy, done}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
